// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART (TXD/RXD/CON). rdata is combinational; TX starts one cycle after a TXD store.
// No backpressure: TXD stores while busy are dropped, and a new RX byte overwrites an unread one (flags OVR).
module uart_peripheral #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irqout
);

  localparam int              CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [31:0]     ADDR_TXD  = 32'h4000_0018;
  localparam logic [31:0]     ADDR_RXD  = 32'h4000_001C;
  localparam logic [31:0]     ADDR_CON  = 32'h4000_0020;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          tx_state, tx_state_nxt, rx_state, rx_state_nxt;
  logic [CW-1:0]   tx_cnt, tx_cnt_nxt, rx_cnt, rx_cnt_nxt;
  logic [2:0]      tx_bit, tx_bit_nxt, tx_bit_inc, rx_bit, rx_bit_nxt;
  logic [7:0]      tx_byte, rx_shift, rx_shift_nxt, rx_byte;
  logic            tx_line_nxt, tx_accept, tx_done_set, tx_tick, tx_busy;
  logic            rx_meta, rx_sync, rx_sync_d, rx_ok, rx_fe;
  logic            tx_ien, rx_ien, tx_done, rx_valid, ovr, fe;
  logic            sel_txd, sel_rxd, sel_con, txd_wr, rxd_rd, con_wr;

  assign sel_txd    = (addr == ADDR_TXD);
  assign sel_rxd    = (addr == ADDR_RXD);
  assign sel_con    = (addr == ADDR_CON);
  assign txd_wr     = wr & sel_txd;
  assign rxd_rd     = rd & sel_rxd;
  assign con_wr     = wr & sel_con;
  assign tx_tick    = (tx_cnt == BIT_LAST);
  assign tx_busy    = (tx_state != S_IDLE);
  assign tx_bit_inc = tx_bit + 3'd1;

  // ---------------- transmitter ----------------
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt + CNT_ONE;
    tx_bit_nxt   = tx_bit;
    tx_line_nxt  = uart_tx;
    tx_accept    = 1'b0;
    tx_done_set  = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_cnt_nxt  = '0;
        tx_line_nxt = 1'b1;
        if (txd_wr) begin
          tx_state_nxt = S_START;
          tx_line_nxt  = 1'b0;
          tx_accept    = 1'b1;
        end
      end
      S_START: if (tx_tick) begin
        tx_state_nxt = S_DATA;
        tx_cnt_nxt   = '0;
        tx_bit_nxt   = 3'd0;
        tx_line_nxt  = tx_byte[0];
      end
      S_DATA: if (tx_tick) begin
        tx_cnt_nxt = '0;
        if (tx_bit == 3'd7) begin
          tx_state_nxt = S_STOP;
          tx_line_nxt  = 1'b1;
        end else begin
          tx_bit_nxt  = tx_bit_inc;
          tx_line_nxt = tx_byte[tx_bit_inc];
        end
      end
      S_STOP: if (tx_tick) begin
        tx_state_nxt = S_IDLE;
        tx_cnt_nxt   = '0;
        tx_line_nxt  = 1'b1;
        tx_done_set  = 1'b1;
      end
      default: tx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      uart_tx  <= 1'b1;
      tx_byte  <= 8'h00;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      uart_tx  <= tx_line_nxt;
      if (tx_accept) tx_byte <= wdata[7:0];
    end
  end

  // ---------------- receiver ----------------
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + CNT_ONE;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_ok        = 1'b0;
    rx_fe        = 1'b0;
    case (rx_state)
      S_IDLE: begin
        rx_cnt_nxt = '0;
        if (rx_sync_d & ~rx_sync) rx_state_nxt = S_START;
      end
      // Mid-start-bit re-check rejects short glitches on the line.
      S_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_nxt   = '0;
        rx_bit_nxt   = 3'd0;
        rx_state_nxt = rx_sync ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_nxt   = '0;
        rx_shift_nxt = {rx_sync, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_nxt = S_STOP;
        else                rx_bit_nxt   = rx_bit + 3'd1;
      end
      S_STOP: if (rx_cnt == BIT_LAST) begin
        rx_state_nxt = S_IDLE;
        rx_cnt_nxt   = '0;
        rx_ok        = rx_sync;
        rx_fe        = ~rx_sync;
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_d <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= 3'd0;
      rx_shift  <= 8'h00;
    end else begin
      rx_meta   <= uart_rx;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
      rx_state  <= rx_state_nxt;
      rx_cnt    <= rx_cnt_nxt;
      rx_bit    <= rx_bit_nxt;
      rx_shift  <= rx_shift_nxt;
    end
  end

  // ---------------- control/status ----------------
  // Set events take priority over clears issued in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ien   <= 1'b0;
      rx_ien   <= 1'b0;
      tx_done  <= 1'b0;
      rx_valid <= 1'b0;
      ovr      <= 1'b0;
      fe       <= 1'b0;
      rx_byte  <= 8'h00;
    end else begin
      if (con_wr) begin
        tx_ien <= wdata[0];
        rx_ien <= wdata[1];
      end
      if (tx_done_set)             tx_done <= 1'b1;
      else if (con_wr & wdata[2])  tx_done <= 1'b0;
      if (rx_ok)                   rx_valid <= 1'b1;
      else if (rxd_rd)             rx_valid <= 1'b0;
      if (rx_ok)                   rx_byte <= rx_shift;
      if (rx_ok & rx_valid)        ovr <= 1'b1;
      else if (con_wr & wdata[5])  ovr <= 1'b0;
      if (rx_fe)                   fe <= 1'b1;
      else if (con_wr & wdata[6])  fe <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      if (sel_txd)      rdata = {24'h0, tx_byte};
      else if (sel_rxd) rdata = {24'h0, rx_byte};
      else if (sel_con) rdata = {25'h0, fe, ovr, tx_busy, rx_valid, tx_done, rx_ien, tx_ien};
    end
  end

  assign irqout = (tx_ien & tx_done) | (rx_ien & rx_valid);

endmodule

// File: tb/tb_uart_peripheral.sv
// Directed bench for uart_peripheral at 8 clocks per bit: TX framing, busy drop, RX/IRQ,
// overrun/framing errors, glitch rejection and reset mid-frame.
module tb_uart_peripheral;

  localparam int          CPB   = 8;
  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
  localparam logic [31:0] A_BAD = 32'h4000_0024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        irqout;

  int n_cmp = 0;
  int n_err = 0;

  uart_peripheral #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .irqout  (irqout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n clocks; leaves time 1 ns after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick(1);
    wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    rd   = 1'b1;
    #1;
    d    = rdata;
    tick(1);
    rd   = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB);
    uart_rx = 1'b1;
    tick(4);
  endtask

  // Expected line level for bit k (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0)      return 1'b0;
    else if (k == 9) return 1'b1;
    else             return b[k-1];
  endfunction

  initial begin
    logic [31:0] v;
    int          lows;

    tick(3);
    reset = 1'b0;
    tick(1);

    // reset state
    chk("rst_tx", 32'(uart_tx), 32'h1);
    chk("rst_irq", 32'(irqout), 32'h0);
    bus_read(A_CON, v); chk("rst_con", v, 32'h0);
    bus_read(A_TXD, v); chk("rst_txd", v, 32'h0);
    bus_read(A_RXD, v); chk("rst_rxd", v, 32'h0);
    bus_read(A_BAD, v); chk("unmapped_rd", v, 32'h0);

    // TX basic: 0xA5 -> 0,1,0,1,0,0,1,0,1,1 each held CPB cycles
    bus_write(A_TXD, 32'h0000_00A5);
    addr = A_CON;
    rd   = 1'b1;
    for (int i = 0; i < 10 * CPB; i++) begin
      #1;
      chk($sformatf("tx_a5_bit%0d", i / CPB), 32'(uart_tx), 32'(fbit(8'hA5, i / CPB)));
      chk("tx_busy", 32'(rdata[4]), 32'h1);
      tick(1);
    end
    #1;
    chk("tx_done_con", rdata, 32'h0000_0004);
    chk("tx_done_irq_masked", 32'(irqout), 32'h0);
    rd = 1'b0;
    #1;
    chk("rd_gate", rdata, 32'h0);
    tick(1);

    // TX busy-drop: second store mid-frame is ignored
    bus_write(A_TXD, 32'h0000_0011);
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i == 20) begin
        addr  = A_TXD;
        wdata = 32'h0000_0022;
        wr    = 1'b1;
      end
      if (i == 21) wr = 1'b0;
      if (i % CPB == CPB / 2)
        chk($sformatf("drop_bit%0d", i / CPB), 32'(uart_tx), 32'(fbit(8'h11, i / CPB)));
      tick(1);
    end
    lows = 0;
    repeat (20) begin
      if (!uart_tx) lows++;
      tick(1);
    end
    chk("drop_no_2nd_frame", 32'(lows), 32'h0);
    bus_read(A_TXD, v); chk("drop_txd", v, 32'h0000_0011);

    // TX_DONE write-1-to-clear
    bus_write(A_CON, 32'h0000_0004);
    bus_read(A_CON, v); chk("w1c_done", v, 32'h0);

    // RX + IRQ
    bus_write(A_CON, 32'h0000_0002);
    rx_frame(8'h3C, 1'b1);
    chk("rx_irq_set", 32'(irqout), 32'h1);
    bus_read(A_CON, v); chk("rx_con_valid", v, 32'h0000_000A);
    bus_read(A_RXD, v); chk("rx_data_3c", v, 32'h0000_003C);
    chk("rx_irq_clr", 32'(irqout), 32'h0);
    bus_read(A_CON, v); chk("rx_con_cleared", v, 32'h0000_0002);

    // overrun
    rx_frame(8'h01, 1'b1);
    rx_frame(8'h02, 1'b1);
    bus_read(A_CON, v); chk("ovr_con", v, 32'h0000_002A);
    bus_read(A_RXD, v); chk("ovr_rxd", v, 32'h0000_0002);

    // framing error: byte discarded, RX_VALID untouched
    rx_frame(8'h55, 1'b0);
    bus_read(A_CON, v); chk("fe_con", v, 32'h0000_0062);
    bus_read(A_RXD, v); chk("fe_rxd_kept", v, 32'h0000_0002);
    bus_write(A_CON, 32'h0000_0060);
    bus_read(A_CON, v); chk("w1c_ovr_fe", v, 32'h0);

    // glitch rejection, then a good frame
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(20);
    bus_read(A_CON, v); chk("glitch_con", v, 32'h0);
    rx_frame(8'hC3, 1'b1);
    bus_read(A_CON, v); chk("post_glitch_con", v, 32'h0000_0008);
    bus_read(A_RXD, v); chk("post_glitch_rxd", v, 32'h0000_00C3);

    // reset during TX DATA
    bus_write(A_CON, 32'h0000_0003);
    bus_write(A_TXD, 32'h0000_0000);
    tick(30);
    chk("pre_rst_line", 32'(uart_tx), 32'h0);
    reset = 1'b1;
    tick(1);
    chk("rst_mid_line", 32'(uart_tx), 32'h1);
    reset = 1'b0;
    bus_read(A_CON, v); chk("rst_mid_con", v, 32'h0);
    lows = 0;
    repeat (100) begin
      if (!uart_tx) lows++;
      tick(1);
    end
    chk("rst_mid_no_residual", 32'(lows), 32'h0);
    bus_read(A_TXD, v); chk("rst_mid_txd", v, 32'h0);
    chk("rst_mid_irq", 32'(irqout), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
